i2s_frame_ctrl: RTL

Stereo frame sequencer between the `i2s` core and the effects pipeline. Pairs the alternating left/right samples from the I2S receive stream into stereo frames and hands each frame to the effects chain. Takes processed frames back and replays them to the I2S transmit stream in left-then-right order. Also provides bypass, mute, and underrun/overrun handling, so the codec always sees valid transmit data.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/axis_if.sv | 12 +
 rtl/sync_2ff.sv | 24 ++
 rtl/i2s_frame_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types for the stereo frame sequencer: sample/frame layout and FSM encodings.
// No logic or latency of its own.
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } frame_t;

  typedef enum logic {LEFT, RIGHT} chan_e;
  typedef enum logic {RX_L, RX_R} rx_state_e;
  typedef enum logic {TX_L, TX_R} tx_state_e;

  // lrck high while the left word completes
  function automatic chan_e chan_of(input logic lrck_s);
    return lrck_s ? LEFT : RIGHT;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream bundle; data is qualified by vld and consumed when vld && rdy.
// Zero latency; the slave backpressures by holding rdy low.
interface axis_if #(
  parameter int W = 24
) ();
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow asynchronous control inputs.
// Latency 2 clk cycles; no handshake.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Pairs I2S RX samples into stereo frames for the effects chain and replays processed frames to I2S TX
// (1-cycle frame/pending latency); fx_out holds one frame, overflow is dropped; TX repeats on underrun. Counters: I2S_FRAME_CTRL_STATS_EN.
module i2s_frame_ctrl
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lrck,
  axis_if.slave                i2s_rx,
  axis_if.master               i2s_tx,
  axis_if.master               fx_out,
  axis_if.slave                fx_in,
  input  logic                 bypass,
  input  logic                 mute,
  output logic [CNT_WIDTH-1:0] underrun_cnt,
  output logic [CNT_WIDTH-1:0] overrun_cnt
);

  logic      lrck_s;
  chan_e     rx_chan;
  logic      rx_hs;
  sample_t   rx_sample;
  rx_state_e rx_state, rx_next;
  logic      store_left, frame_done;
  sample_t   left_q;
  frame_t    rx_frame;

  logic      fx_vld;
  frame_t    fx_q;
  logic      fx_full, fx_load, fx_in_hs;

  logic      pend_vld, pend_wr, pend_rd, pend_fwd;
  frame_t    pend_q, pend_wdat;
  frame_t    cur_q;

  tx_state_e tx_state, tx_next;
  logic      tx_vld, tx_hs, next_load;

  sync_2ff #(.W(1)) u_lrck_sync (
    .clk (clk),
    .rst (rst),
    .d   (lrck),
    .q   (lrck_s)
  );

  assign i2s_rx.rdy = 1'b1;
  assign rx_hs      = i2s_rx.vld;
  assign rx_chan    = chan_of(lrck_s);
  assign rx_sample  = i2s_rx.data[DATA_WIDTH-1:0];
  assign rx_frame   = '{left: left_q, right: rx_sample};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_L;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    store_left = 1'b0;
    frame_done = 1'b0;
    case (rx_state)
      RX_L: if (rx_hs && rx_chan == LEFT) begin
        store_left = 1'b1;
        rx_next    = RX_R;
      end
      RX_R: if (rx_hs) begin
        if (rx_chan == RIGHT) begin
          frame_done = 1'b1;
          rx_next    = RX_L;
        end else begin
          store_left = 1'b1;
        end
      end
      default: rx_next = RX_L;
    endcase
  end

  // A frame being taken this cycle frees the slot for a same-cycle reload
  assign fx_full    = fx_vld && !fx_out.rdy;
  assign fx_load    = frame_done && !bypass && !fx_full;
  assign fx_out.vld = fx_vld;
  assign fx_out.data = fx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
      fx_vld <= 1'b0;
      fx_q   <= '0;
    end else begin
      if (store_left) left_q <= rx_sample;
      if (fx_load) begin
        fx_q   <= rx_frame;
        fx_vld <= 1'b1;
      end else if (fx_out.rdy) begin
        fx_vld <= 1'b0;
      end
    end
  end

  assign fx_in.rdy = bypass || !pend_vld;
  assign fx_in_hs  = fx_in.vld && fx_in.rdy;
  assign pend_wr   = (frame_done && bypass) || (fx_in_hs && !bypass);
  assign pend_wdat = bypass ? rx_frame : frame_t'(fx_in.data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_L;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next   = tx_state;
    next_load = 1'b0;
    case (tx_state)
      TX_L: if (tx_hs) tx_next = TX_R;
      TX_R: if (tx_hs) begin
        tx_next   = TX_L;
        next_load = 1'b1;
      end
      default: tx_next = TX_L;
    endcase
  end

  assign tx_hs    = tx_vld && i2s_tx.rdy;
  assign pend_rd  = next_load && pend_vld;
  // An empty pending buffer written in the load cycle hands its frame straight to TX
  assign pend_fwd = next_load && !pend_vld && pend_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_vld   <= 1'b0;
      pend_vld <= 1'b0;
      pend_q   <= '0;
      cur_q    <= '0;
    end else begin
      tx_vld <= 1'b1;
      if (pend_rd)       cur_q <= pend_q;
      else if (pend_fwd) cur_q <= pend_wdat;
      if (pend_wr && !pend_fwd) begin
        pend_q   <= pend_wdat;
        pend_vld <= 1'b1;
      end else if (pend_rd) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign i2s_tx.vld  = tx_vld;
  assign i2s_tx.data = mute ? '0 : ((tx_state == TX_L) ? cur_q.left : cur_q.right);

`ifdef I2S_FRAME_CTRL_STATS_EN
  logic underrun_ev, overrun_ev;
  assign underrun_ev = next_load && !pend_vld && !pend_wr;
  assign overrun_ev  = frame_done && !bypass && fx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (underrun_ev && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
      if (overrun_ev && overrun_cnt != '1)   overrun_cnt  <= overrun_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign underrun_cnt = '0;
  assign overrun_cnt  = '0;
`endif

endmodule
